mips_dmem_responder: RTL
========================

Name: mips_dmem_responder

Overview:
- Data-memory responder (slave end) for the MIPS core's load/store path.
- Replaces the zero-latency data memory with a valid/ready request channel and a valid/ready response channel, with programmable access latency.
- Lets the core's memory master be built and verified against realistic wait states.
- Holds a DEPTH-word register array and returns exactly one response per accepted request.

Parameters:
- ADDR_W, 5, word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, word width.
- WAIT_CYCLES, 2, extra wait cycles before the access commits; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  master takes the response.
- resp_wr  output  1  echo of the captured req_wr.
- resp_rdata  output  DATA_W  load data, or the just-written word for a store.
- busy  output  1  high in WAIT or RESP.

Behaviour:
- Reset (rst high at a rising edge), all of the following in the same edge:
  - state goes to IDLE.
  - req_ready = 1; resp_valid, resp_wr, busy = 0; resp_rdata = 0.
  - wait counter = 0.
  - every memory word = 0.
- Reset mid-operation: any pending request is dropped with no response; a store that has not yet committed is not written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at an edge: capture req_wr, req_addr, req_wdata; load counter = WAIT_CYCLES; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - req_ready = 0; busy = 1.
  - At each edge with counter != 0: counter decrements.
  - At the edge with counter == 0, the access commits and the state goes to RESP:
    - Store: mem[addr] <= wdata and resp_rdata <= wdata.
    - Load: resp_rdata <= mem[addr].
    - resp_wr <= captured wr; resp_valid <= 1.
- RESP:
  - resp_valid = 1; resp_rdata and resp_wr held stable.
  - On resp_valid & resp_ready at an edge: resp_valid <= 0 and state goes to IDLE.
  - No request is accepted in RESP (req_ready = 0), so there is exactly one outstanding transaction.
- Latency: resp_valid is first visible WAIT_CYCLES+1 cycles after the accepting edge. With WAIT_CYCLES=0, the response appears the cycle after acceptance.
- Throughput: at most one transaction per WAIT_CYCLES+3 cycles when resp_ready is held high.
- Inputs while not in IDLE: req_* changes are ignored and the captured values are used.
- req_valid held high across a completed transaction is accepted again in the following IDLE cycle; this is the master's responsibility.
- Address is taken modulo DEPTH by width; there is no out-of-range condition.
- Read-after-write to the same address in consecutive transactions returns the new value.
- resp_rdata is not cleared on the response handshake; it keeps the last value until the next commit.

Optional Feature:
- Macro: MIPS_DMEM_STATS_EN.
- Defined: adds two outputs, rd_count (16 bits) and wr_count (16 bits).
  - Each increments at the commit edge of a load or a store respectively.
  - Both saturate at 16'hFFFF.
  - Both are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: rst for 1 cycle, then load every address 0..31 -> every resp_rdata = 0; req_ready = 1 in the first cycle after reset.
- Store/load, WAIT_CYCLES=2, resp_ready held 1:
  - Store addr 5 with 32'hDEADBEEF -> resp_valid rises 3 cycles after accept with resp_wr = 1 and resp_rdata = DEADBEEF.
  - Load addr 5 -> resp_rdata = DEADBEEF, resp_wr = 0.
- Backpressure: resp_ready = 0 for 6 cycles after resp_valid rises -> resp_valid and resp_rdata held stable; req_ready = 0 while a new req_valid is driven; that request is accepted only after the handshake.
- WAIT_CYCLES=0 build: back-to-back store addr 31 = 1, then load addr 31 -> each response one cycle after accept; load returns 1; wrap address 32 is not expressible (5-bit).
- Reset mid-op: accept store addr 3 = 32'h12345678, assert rst in the WAIT state -> no resp_valid; a later load of addr 3 returns 0.
- MIPS_DMEM_STATS_EN: 3 stores and 2 loads -> wr_count = 3, rd_count = 2; after rst both = 0.

Source files
------------

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: valid/ready request and response channels around a
// DEPTH-word register array with programmable wait states. MIPS_DMEM_STATS_EN adds load/store counters.
module mips_dmem_responder #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
`ifdef MIPS_DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                cap_wr;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Single-outstanding transaction engine; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_rdata <= '0;
      busy       <= 1'b0;
      cnt        <= '0;
      cap_wr     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
`ifdef MIPS_DMEM_STATS_EN
      rd_count   <= '0;
      wr_count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_wr    <= req_wr;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Commit: stores echo the written word back as the response data.
            if (cap_wr) begin
              mem[cap_addr] <= cap_wdata;
              resp_rdata    <= cap_wdata;
`ifdef MIPS_DMEM_STATS_EN
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
`endif
            end else begin
              resp_rdata <= mem[cap_addr];
`ifdef MIPS_DMEM_STATS_EN
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
`endif
            end
            resp_wr    <= cap_wr;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
